// File: rtl/psum_acc_ctrl_pkg.sv
// rtl/psum_acc_ctrl_pkg.sv - shared types and widths for the partial-sum accumulator
package psum_acc_ctrl_pkg;

    localparam int PROD_N = 8;
    localparam int PROD_W = 8;
    // Eight signed 8-bit products need 3 extra bits of headroom.
    localparam int PSUM_W = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Accumulator grows by LEN_W bits so 2**LEN_W-1 worst-case beats cannot wrap.
    function automatic int acc_width(input int len_w);
        return PSUM_W + len_w;
    endfunction

endpackage

// File: rtl/psum_acc_ctrl_psum.sv
// rtl/psum_acc_ctrl_psum.sv - combinational signed adder tree over eight 8-bit products
import psum_acc_ctrl_pkg::*;

module psum_acc_ctrl_psum (
    input  logic [PROD_N*PROD_W-1:0] products_i,
    output logic signed [PSUM_W-1:0] sum_o
);

    // Sign-extend every product to the full tree width before summing.
    always_comb begin
        sum_o = '0;
        for (int k = 0; k < PROD_N; k++) begin
            sum_o = sum_o + PSUM_W'($signed(products_i[k*PROD_W +: PROD_W]));
        end
    end

endmodule

// File: rtl/psum_acc_ctrl.sv
// rtl/psum_acc_ctrl.sv - command-driven accumulation of reduced product beats
import psum_acc_ctrl_pkg::*;

module psum_acc_ctrl #(
    parameter int LEN_W = 8,
    parameter int ACC_W = acc_width(LEN_W)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_valid,
    input  logic [LEN_W-1:0]            cfg_len,
    output logic                        cfg_ready,
    input  logic                        in_valid,
    input  logic [PROD_N*PROD_W-1:0]    in_products,
    output logic                        in_ready,
    output logic                        out_valid,
    output logic [ACC_W-1:0]            out_sum,
    input  logic                        out_ready,
    output logic                        busy
);

    state_t                    state_q;
    logic [LEN_W-1:0]          beats_left_q;
    logic [LEN_W-1:0]          beats_left_d;
    logic [LEN_W-1:0]          first_len;
    logic [ACC_W-1:0]          acc_q;
    logic [ACC_W-1:0]          acc_d;
    logic signed [PSUM_W-1:0]  stage_q;
    logic                      stage_vld_q;
    logic signed [PSUM_W-1:0]  tree_sum;
    logic                      beat_xfer;
    logic                      out_valid_q;
    logic [ACC_W-1:0]          out_sum_q;

    psum_acc_ctrl_psum u_psum (
        .products_i (in_products),
        .sum_o      (tree_sum)
    );

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign in_ready  = (state_q == ST_RUN) && (beats_left_q != '0);
    assign beat_xfer = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;

    // Next-state arithmetic: pipelined accumulate of the stage value and beat countdown.
    always_comb begin
        acc_d        = acc_q;
        beats_left_d = beats_left_q - LEN_W'(1);
        first_len    = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        if (stage_vld_q) begin
            acc_d = acc_q + {{(ACC_W-PSUM_W){stage_q[PSUM_W-1]}}, stage_q};
        end
    end

    // Controller FSM with datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            acc_q        <= '0;
            stage_q      <= '0;
            stage_vld_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sum_q    <= '0;
        end else begin
            stage_vld_q <= beat_xfer;
            acc_q       <= acc_d;
            if (beat_xfer) begin
                stage_q      <= tree_sum;
                beats_left_q <= beats_left_d;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        beats_left_q <= first_len;
                        acc_q        <= '0;
                        stage_q      <= '0;
                        stage_vld_q  <= 1'b0;
                        state_q      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (beat_xfer && (beats_left_q == LEN_W'(1))) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    // Stage empty here means the last beat is already in acc_q.
                    if (!stage_vld_q) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_sum_q   <= acc_q;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// tb/tb_psum_acc_ctrl.sv - directed scoreboard bench for psum_acc_ctrl
module tb_psum_acc_ctrl;

    localparam int LEN_W = 8;
    localparam int ACC_W = 19;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     cfg_valid;
    logic [LEN_W-1:0]         cfg_len;
    logic                     cfg_ready;
    logic                     in_valid;
    logic [63:0]              in_products;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_sum;
    logic                     out_ready;
    logic                     busy;

    int total = 0;
    int bad   = 0;

    int          sb_q[$];
    logic [63:0] beat_q[$];
    int          vpat[$];

    psum_acc_ctrl #(.LEN_W(LEN_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_len     (cfg_len),
        .cfg_ready   (cfg_ready),
        .in_valid    (in_valid),
        .in_products (in_products),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_sum     (out_sum),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int beat_sum(input logic [63:0] p);
        int s = 0;
        for (int k = 0; k < 8; k++) s += int'($signed(p[k*8 +: 8]));
        return s;
    endfunction

    function automatic logic [63:0] fill(input logic [7:0] b);
        return {8{b}};
    endfunction

    // Runs one command; beat_q holds the beats, vpat the in_valid pattern (1 after it ends).
    task automatic run_job(input int len, input string tag, input int exp_lat,
                           input bit poke_cfg, input bit rdy_during);
        int n;
        int sum;
        int cyc;
        int xfers;
        int extra_rdy;
        n   = (len == 0) ? 1 : len;
        sum = 0;
        for (int i = 0; i < n; i++) sum += beat_sum(beat_q[i]);
        sb_q.push_back(sum);
        cfg_valid = 1'b1;
        cfg_len   = LEN_W'(len);
        tick();
        cfg_valid = 1'b0;
        out_ready = rdy_during;
        cyc = 0; xfers = 0; extra_rdy = 0;
        while (!out_valid && cyc < 2000) begin
            if (poke_cfg && cyc == 1) begin
                cfg_valid = 1'b1;
                cfg_len   = 8'd1;
            end else begin
                cfg_valid = 1'b0;
            end
            in_valid    = (cyc < vpat.size()) ? (vpat[cyc] != 0) : 1'b1;
            in_products = (xfers < n) ? beat_q[xfers] : {$urandom, $urandom};
            if (xfers >= n && in_ready) extra_rdy++;
            if (in_valid && in_ready) xfers++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        check({tag, "_out_valid"}, out_valid, 1);
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_beats"}, xfers, n);
        check({tag, "_no_extra_ready"}, extra_rdy, 0);
        check({tag, "_sum"}, out_sum, sb_q.pop_front());
    endtask

    // Holds out_ready low, checks the result is stable, then completes the handshake.
    task automatic finish_job(input string tag, input int hold);
        logic signed [ACC_W-1:0] held;
        out_ready = 1'b0;
        held = out_sum;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_sum"}, out_sum, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, cfg_ready, 1);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_len = '0; in_valid = 1'b0;
        in_products = '0; out_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cfg_valid   = 1'($urandom);
            cfg_len     = LEN_W'($urandom);
            in_valid    = 1'($urandom);
            in_products = {$urandom, $urandom};
            out_ready   = 1'($urandom);
            tick();
        end
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();

        // in_valid in IDLE is not accepted
        in_valid = 1'b1;
        tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        in_valid = 1'b0;

        // len=1, all 8'h7F; out_ready high outside DONE is ignored
        beat_q = {fill(8'h7F)}; vpat = {};
        run_job(1, "len1", 4, 1'b0, 1'b1);
        check("len1_value", out_sum, 1016);
        finish_job("len1", 0);

        // len=4, all -128, continuous
        beat_q = {}; for (int i = 0; i < 4; i++) beat_q.push_back(fill(8'h80));
        vpat = {};
        run_job(4, "len4", 7, 1'b0, 1'b0);
        check("len4_value", out_sum, -4096);
        finish_job("len4", 1);

        // len=3, stalled beats, cfg_valid poked mid-RUN
        beat_q = {64'h05, 64'hF9, 64'h02};
        vpat = {1, 0, 0, 1, 0, 1};
        run_job(3, "len3", -1, 1'b1, 1'b0);
        check("len3_value", out_sum, 0);
        finish_job("len3", 2);

        // len=0 treated as a single beat
        beat_q = {64'h0102_0304_FFFE_FDFC}; vpat = {0, 1};
        run_job(0, "len0", 5, 1'b0, 1'b0);
        finish_job("len0", 0);

        // len=255, all -128, result held under back-pressure
        beat_q = {}; for (int i = 0; i < 255; i++) beat_q.push_back(fill(8'h80));
        vpat = {};
        run_job(255, "len255", 258, 1'b0, 1'b0);
        check("len255_value", out_sum, -261120);
        finish_job("len255", 5);

        // Reset mid-RUN abandons the command
        beat_q = {}; for (int i = 0; i < 10; i++) beat_q.push_back(fill(8'h11));
        cfg_valid = 1'b1; cfg_len = 8'd10;
        tick();
        cfg_valid = 1'b0;
        in_valid = 1'b1; in_products = fill(8'h11);
        tick(); tick();
        cfg_valid = 1'b1; cfg_len = 8'd2;
        tick();
        cfg_valid = 1'b0;
        check("midrun_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        check("midrun_cfg_ready", cfg_ready, 1);
        check("midrun_busy_after", busy, 0);
        check("midrun_out_valid", out_valid, 0);
        check("midrun_out_sum", out_sum, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (out_valid) seen++;
            end
            check("midrun_no_output", seen, 0);
        end

        // Reset in DONE drops the result
        beat_q = {fill(8'h03)}; vpat = {};
        run_job(1, "predone", 4, 1'b0, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("done_rst_valid", out_valid, 0);
        check("done_rst_ready", cfg_ready, 1);

        // Fresh command after reset starts from a cleared accumulator
        beat_q = {fill(8'h01), fill(8'hFF), fill(8'h10)}; vpat = {};
        run_job(3, "fresh", 6, 1'b0, 1'b0);
        check("fresh_value", out_sum, 128);
        finish_job("fresh", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
